// File: rtl/serial_add_pkg.sv
// Shared constants for the bit-serial adder: FSM encodings and the
// bit-counter width helper.
package serial_add_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Counter must index bits 0..width-1; never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_add_full_add.sv
// Gate-level one-bit full adder, the additive twin of full_sub.
module full_add (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic axb;

  assign axb = a ^ b;
  assign s   = axb ^ ci;
  assign co  = (a & b) | (axb & ci);

endmodule

// File: rtl/serial_add.sv
// Bit-serial ripple adder: one full-adder cell and a carry flop process
// one bit per clock, LSB first, behind a start/busy/done handshake.
//
// Handshake: start is sampled only in IDLE or DONE; the accepting edge
// captures a/b/ci. busy is high for the WIDTH RUN cycles, done pulses for
// one cycle when sum/co become valid, and sum/co hold until the next
// completion (they are never partial).
module serial_add
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             co
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s;
  logic             fa_c;
  logic [WIDTH-1:0] res_next;

  full_add u_fa (
    .a  (op_a[0]),
    .b  (op_b[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_c)
  );

  // res_next is the result register after this edge's shift; the last
  // edge's value is the complete sum, so only WIDTH-1 bits need storage.
  if (WIDTH == 1) begin : g_res_w1
    assign res_next = fa_s;
  end else begin : g_res_wn
    logic [WIDTH-2:0] res;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        res <= '0;
      end else if (state == ST_RUN) begin
        res <= res_next[WIDTH-1:1];
      end
    end

    assign res_next = {fa_s, res};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      op_a  <= '0;
      op_b  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      co    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            op_a  <= a;
            op_b  <= b;
            carry <= ci;
            cnt   <= '0;
            state <= ST_RUN;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          op_a  <= op_a >> 1;
          op_b  <= op_b >> 1;
          carry <= fa_c;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            sum   <= res_next;
            co    <= fa_c;
            state <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

endmodule
